// File: rtl/mole_autoplayer_if.sv
// Mole autoplayer bus: game-side controls in, switch drive and stats out.
// master = game/host side, slave = autoplayer.
interface mole_autoplayer_if #(
   parameter int N = 8
);
   logic         pause;
   logic         enable;
   logic [N-1:0] led;
   logic [N-1:0] sw;
   logic [3:0]   round;
   logic [15:0]  press_count;
   logic [15:0]  skip_count;
   logic         busy;

   modport master (
      output pause, enable, led,
      input  sw, round, press_count, skip_count, busy
   );

   modport slave (
      input  pause, enable, led,
      output sw, round, press_count, skip_count, busy
   );
endinterface

// File: rtl/mole_autoplayer.sv
// Whack-a-mole autoplayer: waits a reaction delay, presses the captured
// pattern for a hold window, rests for a gap, then advances the round.
module mole_autoplayer #(
   parameter int           N            = 8,
   parameter int           REACT_CYCLES = 40,
   parameter int           HOLD_CYCLES  = 40,
   parameter int           SKIP_ROUND   = 4,
   parameter logic [N-1:0] SEED         = N'(8),
   parameter int           MODE         = 0
) (
   input  logic          clk,
   input  logic          rst,
   mole_autoplayer_if.slave bus
);
   localparam int MAXC = (REACT_CYCLES > HOLD_CYCLES) ?
                         REACT_CYCLES : HOLD_CYCLES;
   localparam int W = $clog2(MAXC + 1);
   localparam logic [W-1:0] REACT_LD = W'(REACT_CYCLES - 1);
   localparam logic [W-1:0] HOLD_LD  = W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, REACT, PRESS, GAP} state_t;

   state_t       state;
   logic [W-1:0] cnt;
   logic [N-1:0] sw_q;
   logic [3:0]   round_q;
   logic [15:0]  press_q;
   logic [15:0]  skip_q;

   logic [N-1:0] low;
   logic [N-1:0] pat;
   logic         skip_now;
   logic         zero_miss;

   always_comb begin
      low       = bus.led & (~bus.led + N'(1));
      skip_now  = (SKIP_ROUND != 0) &&
                  ({28'd0, round_q} == SKIP_ROUND);
      zero_miss = (round_q != 4'd0) && !skip_now &&
                  (bus.led == '0);
      if (round_q == 4'd0)
         pat = SEED;
      else if (skip_now)
         pat = '0;
      else if (MODE == 1)
         pat = low;
      else
         pat = bus.led;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         sw_q    <= '0;
         round_q <= '0;
         press_q <= '0;
         skip_q  <= '0;
      end else if (!bus.pause) begin
         unique case (state)
            IDLE: begin
               if (bus.enable) begin
                  state <= REACT;
                  cnt   <= REACT_LD;
               end
            end
            REACT: begin
               if (cnt != '0) begin
                  cnt <= cnt - W'(1);
               end else if (zero_miss) begin
                  // no mole lit yet: wait another full reaction window
                  cnt <= REACT_LD;
               end else begin
                  state <= PRESS;
                  sw_q  <= pat;
                  cnt   <= HOLD_LD;
                  if (pat != '0) begin
                     if (press_q != 16'hFFFF)
                        press_q <= press_q + 16'd1;
                  end else if (skip_q != 16'hFFFF) begin
                     skip_q <= skip_q + 16'd1;
                  end
               end
            end
            PRESS: begin
               if (cnt != '0) begin
                  cnt <= cnt - W'(1);
               end else begin
                  state <= GAP;
                  sw_q  <= '0;
                  cnt   <= HOLD_LD;
               end
            end
            GAP: begin
               if (cnt != '0) begin
                  cnt <= cnt - W'(1);
               end else begin
                  state   <= IDLE;
                  round_q <= round_q + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.sw          = sw_q;
   assign bus.round       = round_q;
   assign bus.press_count = press_q;
   assign bus.skip_count  = skip_q;
   assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_mole_autoplayer.sv
// Directed bench for mole_autoplayer: MODE 0 and MODE 1 instances
// share stimulus; each round is 121 clocks from its start edge.
module tb_mole_autoplayer;
   logic       clk;
   logic       rst;
   logic       pause;
   logic       enable;
   logic [7:0] led;

   int compared;
   int mismatched;

   mole_autoplayer_if #(.N(8)) b0 ();
   mole_autoplayer_if #(.N(8)) b1 ();

   assign b0.pause  = pause;
   assign b0.enable = enable;
   assign b0.led    = led;
   assign b1.pause  = pause;
   assign b1.enable = enable;
   assign b1.led    = led;

   mole_autoplayer #(.N(8), .MODE(0)) u0 (
      .clk(clk),
      .rst(rst),
      .bus(b0.slave)
   );

   mole_autoplayer #(.N(8), .MODE(1)) u1 (
      .clk(clk),
      .rst(rst),
      .bus(b1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // n rising edges, then settle on the following falling edge
   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; pause = 1'b0; enable = 1'b0; led = 8'h00;
      adv(3);
      compared++;
      if (b0.sw !== 8'h00) begin mismatched++; $display("FAIL rst_sw got=%h exp=00", b0.sw); end
      compared++;
      if (b0.round !== 4'd0) begin mismatched++; $display("FAIL rst_round got=%0d exp=0", b0.round); end
      compared++;
      if (b0.press_count !== 16'd0 || b0.skip_count !== 16'd0) begin
         mismatched++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", b0.press_count, b0.skip_count);
      end
      compared++;
      if (b0.busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy got=%b exp=0", b0.busy); end
   endtask

   task automatic test_seed_round();
      rst = 1'b0; enable = 1'b1; led = 8'h00;
      adv(40);
      compared++;
      if (b0.sw !== 8'h00 || b0.busy !== 1'b1) begin
         mismatched++; $display("FAIL r0_react got sw=%h busy=%b exp=00/1", b0.sw, b0.busy);
      end
      adv(1);
      compared++;
      if (b0.sw !== 8'h08 || b1.sw !== 8'h08) begin
         mismatched++; $display("FAIL r0_press got=%h/%h exp=08/08", b0.sw, b1.sw);
      end
      compared++;
      if (b0.press_count !== 16'd1) begin mismatched++; $display("FAIL r0_pcount got=%0d exp=1", b0.press_count); end
      adv(39);
      compared++;
      if (b0.sw !== 8'h08) begin mismatched++; $display("FAIL r0_last got=%h exp=08", b0.sw); end
      adv(1);
      compared++;
      if (b0.sw !== 8'h00) begin mismatched++; $display("FAIL r0_gap got=%h exp=00", b0.sw); end
      adv(39);
      compared++;
      if (b0.round !== 4'd0 || b0.busy !== 1'b1) begin
         mismatched++; $display("FAIL r0_gapend got round=%0d busy=%b exp=0/1", b0.round, b0.busy);
      end
      adv(1);
      compared++;
      if (b0.round !== 4'd1 || b0.busy !== 1'b0) begin
         mismatched++; $display("FAIL r0_done got round=%0d busy=%b exp=1/0", b0.round, b0.busy);
      end
   endtask

   task automatic test_mode_capture();
      led = 8'h24;
      adv(41);
      compared++;
      if (b0.sw !== 8'h24) begin mismatched++; $display("FAIL r1_mode0 got=%h exp=24", b0.sw); end
      compared++;
      if (b1.sw !== 8'h04) begin mismatched++; $display("FAIL r1_mode1 got=%h exp=04", b1.sw); end
      led = 8'hFF;
      adv(10);
      compared++;
      if (b0.sw !== 8'h24 || b1.sw !== 8'h04) begin
         mismatched++; $display("FAIL r1_ledchg got=%h/%h exp=24/04", b0.sw, b1.sw);
      end
      adv(29);
      compared++;
      if (b0.sw !== 8'h24) begin mismatched++; $display("FAIL r1_last got=%h exp=24", b0.sw); end
      adv(1);
      compared++;
      if (b0.sw !== 8'h00 || b1.sw !== 8'h00) begin
         mismatched++; $display("FAIL r1_gap got=%h/%h exp=00/00", b0.sw, b1.sw);
      end
      adv(40);
      compared++;
      if (b0.round !== 4'd2) begin mismatched++; $display("FAIL r1_done got=%0d exp=2", b0.round); end
   endtask

   task automatic test_led_zero_wait();
      led = 8'h00;
      adv(100);
      compared++;
      if (b0.sw !== 8'h00 || b0.round !== 4'd2 || b0.press_count !== 16'd2) begin
         mismatched++;
         $display("FAIL r2_wait got sw=%h round=%0d pc=%0d exp=00/2/2", b0.sw, b0.round, b0.press_count);
      end
      led = 8'h10;
      adv(20);
      compared++;
      if (b0.sw !== 8'h00) begin mismatched++; $display("FAIL r2_prewin got=%h exp=00", b0.sw); end
      adv(1);
      compared++;
      if (b0.sw !== 8'h10 || b1.sw !== 8'h10) begin
         mismatched++; $display("FAIL r2_press got=%h/%h exp=10/10", b0.sw, b1.sw);
      end
      adv(39);
      compared++;
      if (b0.sw !== 8'h10) begin mismatched++; $display("FAIL r2_last got=%h exp=10", b0.sw); end
      adv(1);
      compared++;
      if (b0.sw !== 8'h00) begin mismatched++; $display("FAIL r2_gap got=%h exp=00", b0.sw); end
      adv(39);
      compared++;
      if (b0.round !== 4'd2) begin mismatched++; $display("FAIL r2_hold got=%0d exp=2", b0.round); end
      adv(1);
      compared++;
      if (b0.round !== 4'd3 || b0.press_count !== 16'd3) begin
         mismatched++; $display("FAIL r2_done got round=%0d pc=%0d exp=3/3", b0.round, b0.press_count);
      end
   endtask

   task automatic test_pause_enable();
      led = 8'h42;
      adv(41);
      compared++;
      if (b0.sw !== 8'h42 || b1.sw !== 8'h02) begin
         mismatched++; $display("FAIL r3_press got=%h/%h exp=42/02", b0.sw, b1.sw);
      end
      adv(10);
      pause = 1'b1;
      led = 8'h00;
      adv(25);
      compared++;
      if (b0.sw !== 8'h42 || b0.round !== 4'd3 || b0.busy !== 1'b1) begin
         mismatched++; $display("FAIL r3_paused got sw=%h round=%0d exp=42/3", b0.sw, b0.round);
      end
      pause = 1'b0;
      adv(29);
      compared++;
      if (b0.sw !== 8'h42) begin mismatched++; $display("FAIL r3_stretch got=%h exp=42", b0.sw); end
      adv(1);
      compared++;
      if (b0.sw !== 8'h00) begin mismatched++; $display("FAIL r3_gap got=%h exp=00", b0.sw); end
      enable = 1'b0;
      adv(40);
      compared++;
      if (b0.round !== 4'd4 || b0.busy !== 1'b0) begin
         mismatched++; $display("FAIL r3_done got round=%0d busy=%b exp=4/0", b0.round, b0.busy);
      end
      adv(5);
      compared++;
      if (b0.busy !== 1'b0 || b0.round !== 4'd4) begin
         mismatched++; $display("FAIL r3_disabled got busy=%b round=%0d exp=0/4", b0.busy, b0.round);
      end
      enable = 1'b1;
   endtask

   task automatic test_skip_round();
      led = 8'hFF;
      adv(41);
      compared++;
      if (b0.sw !== 8'h00 || b0.busy !== 1'b1) begin
         mismatched++; $display("FAIL r4_skip got sw=%h busy=%b exp=00/1", b0.sw, b0.busy);
      end
      compared++;
      if (b0.skip_count !== 16'd1 || b0.press_count !== 16'd4) begin
         mismatched++; $display("FAIL r4_counts got=%0d/%0d exp=1/4", b0.skip_count, b0.press_count);
      end
      adv(80);
      compared++;
      if (b0.round !== 4'd5) begin mismatched++; $display("FAIL r4_done got=%0d exp=5", b0.round); end
   endtask

   task automatic test_wrap();
      logic [3:0] exp_r;
      led = 8'h01;
      for (int r = 5; r < 16; r++) begin
         adv(121);
         exp_r = 4'(r + 1);
         compared++;
         if (b0.round !== exp_r) begin mismatched++; $display("FAIL wrap_round got=%0d exp=%0d", b0.round, exp_r); end
      end
      led = 8'h81;
      adv(41);
      compared++;
      if (b0.sw !== 8'h08 || b1.sw !== 8'h08) begin
         mismatched++; $display("FAIL r16_seed got=%h/%h exp=08/08", b0.sw, b1.sw);
      end
      compared++;
      if (b0.press_count !== 16'd16 || b0.skip_count !== 16'd1) begin
         mismatched++; $display("FAIL r16_counts got=%0d/%0d exp=16/1", b0.press_count, b0.skip_count);
      end
   endtask

   task automatic test_async_reset();
      adv(5);
      #2 rst = 1'b1;
      #1;
      compared++;
      if (b0.sw !== 8'h00 || b1.sw !== 8'h00) begin
         mismatched++; $display("FAIL arst_sw got=%h/%h exp=00/00", b0.sw, b1.sw);
      end
      compared++;
      if (b0.press_count !== 16'd0 || b0.skip_count !== 16'd0 || b0.round !== 4'd0 || b0.busy !== 1'b0) begin
         mismatched++;
         $display("FAIL arst_state got pc=%0d sc=%0d round=%0d busy=%b exp=0/0/0/0",
                  b0.press_count, b0.skip_count, b0.round, b0.busy);
      end
      @(negedge clk);
      rst = 1'b0;
      led = 8'h00;
      adv(41);
      compared++;
      if (b0.sw !== 8'h08 || b0.press_count !== 16'd1 || b0.round !== 4'd0) begin
         mismatched++;
         $display("FAIL arst_restart got sw=%h pc=%0d round=%0d exp=08/1/0", b0.sw, b0.press_count, b0.round);
      end
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      test_reset();
      test_seed_round();
      test_mode_capture();
      test_led_zero_wait();
      test_pause_enable();
      test_skip_round();
      test_wrap();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/mole_autoplayer.md
MOLE_AUTOPLAYER -- requirements
Module: mole_autoplayer

Interface
REQ-001 Parameter N, default 8: number of mole/switch channels, 1..16.
REQ-002 Parameter REACT_CYCLES, default 40: clocks from round start to press, >=1.
REQ-003 Parameter HOLD_CYCLES, default 40: clocks sw is held asserted, >=1.
REQ-004 Parameter SKIP_ROUND, default 4: round index on which no press is made; 0 disables skipping.
REQ-005 Parameter SEED, default N'b00001000: pattern pressed on round 0.
REQ-006 Parameter MODE, default 0: 0 = mirror all lit led bits; 1 = press lowest set led bit only.
REQ-007 clk  input  1  system clock; all state changes on its rising edge.
REQ-008 rst  input  1  reset, asynchronous and active-high.
REQ-009 pause  input  1  high freezes all state, counters and outputs.
REQ-010 enable  input  1  high allows new rounds to start.
REQ-011 led  input  N  current mole pattern from the game core.
REQ-012 sw  output  N  registered switch drive to the game core.
REQ-013 round  output  4  current round index, wraps 15->0.
REQ-014 press_count  output  16  presses issued, saturating.
REQ-015 skip_count  output  16  rounds skipped deliberately, saturating.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 States SHALL be IDLE, REACT, PRESS, GAP.
REQ-018 IDLE->REACT when enable=1 and pause=0; reaction counter loads REACT_CYCLES-1.
REQ-019 REACT SHALL decrement each unpaused clock; at 0 capture pattern P and go to PRESS.
REQ-020 P SHALL be: SEED if round=0; all-zero if SKIP_ROUND!=0 and round=SKIP_ROUND; otherwise led (MODE 0) or lowest set bit of led (MODE 1).
REQ-021 If round!=0, not a skip round, and led=0 at capture, REACT SHALL reload REACT_CYCLES-1 and re-sample; round does not advance.
REQ-022 PRESS SHALL drive sw=P for exactly HOLD_CYCLES clocks, sw changes registered (one clock after state entry).
REQ-023 sw SHALL ignore led changes during PRESS; only captured P is driven.
REQ-024 On PRESS entry press_count increments if P!=0, skip_count increments if P=0 (skip round); both saturate at 16'hFFFF.
REQ-025 PRESS->GAP after HOLD_CYCLES; sw=0 in GAP; GAP lasts HOLD_CYCLES clocks, then round increments mod 16 and state -> IDLE.
REQ-026 sw SHALL be 0 in IDLE, REACT and GAP.
REQ-027 pause=1 SHALL hold state, counters, round and sw unchanged; pause has priority over enable.
REQ-028 enable deasserted mid-round SHALL NOT abort the round; it only blocks IDLE->REACT.
REQ-029 busy SHALL be combinational from state (state!=IDLE).
REQ-030 Internal counters SHALL be sized ceil(log2(max(REACT_CYCLES,HOLD_CYCLES)+1)) bits.

Reset
REQ-031 rst=1 SHALL asynchronously force state=IDLE, sw=0, round=0, press_count=0, skip_count=0, internal counters=0.
REQ-032 rst asserted mid-PRESS SHALL drop sw to 0 immediately without waiting for a clock edge.
REQ-033 After rst release, first round SHALL be round 0 (SEED).

Verification
REQ-034 Defaults, enable=1, led=8'h00 after reset -> sw=8'h08 from clock 41 to 80 after start, press_count=1, round=1 after GAP.
REQ-035 Round 1, led=8'h24, MODE 0 -> sw=8'h24 for 40 clocks; MODE 1 -> sw=8'h04.
REQ-036 Run to round 4 with led=8'hFF -> sw stays 0 through PRESS, skip_count=1, press_count=4, round then 5.
REQ-037 Round 2, led=0 for 100 clocks then 8'h10 -> no press until led nonzero, then sw=8'h10 after one full REACT_CYCLES window, round unchanged until GAP ends.
REQ-038 pause=1 for 25 clocks mid-PRESS -> sw held, PRESS lasts 65 total clocks; rst pulse mid-PRESS -> sw=0 same cycle, all counts 0.
REQ-039 Run 16 rounds -> round wraps 15->0 and round 16 presses SEED again.
